// File: rtl/snitch_tcdm_bank_pkg.sv
// Shared types for the TCDM bank request controller and its response buffer.
package snitch_tcdm_bank_pkg;

    localparam int unsigned TcdmBankPorts = 2;

    typedef logic port_id_t;

    typedef struct packed {
        port_id_t port;
        logic     write;
    } rsp_tag_t;

    typedef logic [9:0]  default_addr_t;
    typedef logic [7:0]  default_strb_t;
    typedef logic [63:0] default_data_t;

endpackage

// File: rtl/snitch_tcdm_bank_ctrl_if.sv
// Requestor-side bundle of one TCDM bank: per-port request channel plus
// per-port response valid/ready with a shared response data word.
interface snitch_tcdm_bank_ctrl_if
    import snitch_tcdm_bank_pkg::*;
#(
    parameter int unsigned NumPorts = TcdmBankPorts,
    parameter type tcdm_mem_addr_t  = default_addr_t,
    parameter type strb_t           = default_strb_t,
    parameter type data_t           = default_data_t
);

    logic [NumPorts-1:0] req_valid;
    logic [NumPorts-1:0] req_ready;
    tcdm_mem_addr_t      req_addr [NumPorts];
    logic [NumPorts-1:0] req_write;
    strb_t               req_strb [NumPorts];
    data_t               req_data [NumPorts];
    logic [NumPorts-1:0] rsp_valid;
    logic [NumPorts-1:0] rsp_ready;
    data_t               rsp_data;

    modport master (
        output req_valid, req_addr, req_write, req_strb, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_strb, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/snitch_tcdm_rsp_buf.sv
// Circular response FIFO of {tag, data}; the caller never pushes when full
// and never pops when empty.
module snitch_tcdm_rsp_buf
    import snitch_tcdm_bank_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter type data_t        = default_data_t,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  rsp_tag_t        push_tag_i,
    input  data_t           push_data_i,
    input  logic            pop_i,
    output logic            empty_o,
    output rsp_tag_t        head_tag_o,
    output data_t           head_data_o,
    output logic [CntW-1:0] count_o
);

    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    rsp_tag_t        tag_mem_q  [Depth];
    data_t           data_mem_q [Depth];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wptr_d  = push_i ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = pop_i  ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: it is only observed while count_q > 0.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            tag_mem_q[wptr_q]  <= push_tag_i;
            data_mem_q[wptr_q] <= push_data_i;
        end
    end

    assign empty_o     = (count_q == '0);
    assign head_tag_o  = tag_mem_q[rptr_q];
    assign head_data_o = data_mem_q[rptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/snitch_tcdm_bank_ctrl.sv
// Per-bank controller: round-robin arbitration of two ports onto a latency-1
// SRAM, with credit-checked response buffering and an empty-buffer bypass.
module snitch_tcdm_bank_ctrl
    import snitch_tcdm_bank_pkg::*;
#(
    parameter int unsigned NumPorts = TcdmBankPorts,
    parameter int unsigned RspDepth = 2,
    parameter type tcdm_mem_addr_t  = default_addr_t,
    parameter type strb_t           = default_strb_t,
    parameter type data_t           = default_data_t
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    snitch_tcdm_bank_ctrl_if.slave   port_if,
    output logic                     mem_cs_o,
    output tcdm_mem_addr_t           mem_add_o,
    output logic                     mem_wen_o,
    output strb_t                    mem_be_o,
    output data_t                    mem_wdata_o,
    input  data_t                    mem_rdata_i
);

    localparam int unsigned CntW = $clog2(RspDepth + 1);

    port_id_t            rr_q, rr_d;
    logic                inflight_q, inflight_d;
    rsp_tag_t            tag_q, tag_d;

    logic                credit_ok;
    logic                gnt_valid;
    port_id_t            gnt_port;
    port_id_t            sel;
    logic [NumPorts-1:0] gnt_vec;
    logic [NumPorts-1:0] rsp_valid;
    data_t               rsp_data;

    logic [CntW-1:0]     buf_count;
    logic                buf_empty;
    rsp_tag_t            head_tag;
    data_t               head_data;
    logic                bypass;
    logic                push;
    logic                pop;

    // Credit counts the access in flight plus buffered words, so a response
    // always has a slot by the time it returns from the SRAM.
    assign credit_ok = (32'(inflight_q) + 32'(buf_count)) < RspDepth;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_port  = rr_q;
        if (credit_ok) begin
            case (port_if.req_valid)
                2'b11: begin
                    gnt_valid = 1'b1;
                    gnt_port  = rr_q;
                end
                2'b01: begin
                    gnt_valid = 1'b1;
                    gnt_port  = 1'b0;
                end
                2'b10: begin
                    gnt_valid = 1'b1;
                    gnt_port  = 1'b1;
                end
                default: gnt_valid = 1'b0;
            endcase
        end
    end

    always_comb begin
        gnt_vec = '0;
        if (gnt_valid) gnt_vec[gnt_port] = 1'b1;
    end

    assign port_if.req_ready = gnt_vec;

    assign sel         = gnt_valid ? gnt_port : 1'b0;
    assign mem_cs_o    = gnt_valid;
    assign mem_wen_o   = gnt_valid & port_if.req_write[sel];
    assign mem_add_o   = port_if.req_addr[sel];
    assign mem_be_o    = port_if.req_strb[sel];
    assign mem_wdata_o = port_if.req_data[sel];

    assign inflight_d  = gnt_valid;
    assign tag_d       = '{port: sel, write: port_if.req_write[sel]};
    assign rr_d        = gnt_valid ? ~gnt_port : rr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= 1'b0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            rr_q       <= rr_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    // Buffered entries keep the raw SRAM word; write acks are zeroed on the way out.
    assign bypass = inflight_q & buf_empty & port_if.rsp_ready[tag_q.port];
    assign push   = inflight_q & ~bypass;
    assign pop    = ~buf_empty & port_if.rsp_ready[head_tag.port];

    snitch_tcdm_rsp_buf #(
        .Depth  (RspDepth),
        .data_t (data_t)
    ) i_rsp_buf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .push_tag_i  (tag_q),
        .push_data_i (mem_rdata_i),
        .pop_i       (pop),
        .empty_o     (buf_empty),
        .head_tag_o  (head_tag),
        .head_data_o (head_data),
        .count_o     (buf_count)
    );

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (!buf_empty) begin
            rsp_valid[head_tag.port] = 1'b1;
            rsp_data                 = head_tag.write ? '0 : head_data;
        end else if (inflight_q) begin
            rsp_valid[tag_q.port] = 1'b1;
            rsp_data              = tag_q.write ? '0 : mem_rdata_i;
        end
    end

    assign port_if.rsp_valid = rsp_valid;
    assign port_if.rsp_data  = rsp_data;

    for (genvar p = 0; p < NumPorts; p++) begin : gen_req_hold
        a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (port_if.req_valid[p] && !port_if.req_ready[p]) |=>
            (port_if.req_valid[p] &&
             $stable({port_if.req_write[p], port_if.req_addr[p],
                      port_if.req_strb[p], port_if.req_data[p]})));
    end

endmodule

// File: tb/tb_snitch_tcdm_bank_ctrl.sv
// Directed and randomized bench for snitch_tcdm_bank_ctrl with an in-order
// response scoreboard, a golden memory image and a behavioural SRAM.
module tb_snitch_tcdm_bank_ctrl;
    import snitch_tcdm_bank_pkg::*;

    localparam int unsigned RspDepth = 2;

    typedef struct {
        bit            port;
        default_data_t data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    snitch_tcdm_bank_ctrl_if bus ();

    logic          mem_cs, mem_wen;
    default_addr_t mem_add;
    default_strb_t mem_be;
    default_data_t mem_wdata, mem_rdata;

    snitch_tcdm_bank_ctrl #(.RspDepth(RspDepth)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .port_if     (bus),
        .mem_cs_o    (mem_cs),
        .mem_add_o   (mem_add),
        .mem_wen_o   (mem_wen),
        .mem_be_o    (mem_be),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    function automatic default_data_t init_word(input int a);
        if (a == 'h10) return 64'h0000_0000_DEAD_BEEF;
        return {32'(a) * 32'h9E37_79B9, 32'(a) ^ 32'hA5A5_5A5A};
    endfunction

    default_data_t sram [1024];
    bit sram_init = 1'b0;
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int a = 0; a < 1024; a++) sram[a] = init_word(a);
            sram_init = 1'b1;
        end
        if (mem_cs) begin
            if (mem_wen) begin
                for (int b = 0; b < 8; b++)
                    if (mem_be[b]) sram[mem_add][b*8 +: 8] = mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= sram[mem_add];
            end
        end
    end

    int            checks = 0;
    int            failures = 0;
    exp_t          expq[$];
    default_data_t golden [1024];
    bit            last_gnt;
    logic [1:0]    acc;
    int            comp [2];
    int            grants [2];
    default_data_t last_rsp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        expq.delete();
        last_gnt = 1'b1;
        acc      = 2'b00;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_mem_cs"},    64'(mem_cs),        64'd0);
        chk({tag, "_mem_wen"},   64'(mem_wen),       64'd0);
        chk({tag, "_rsp_data"},  bus.rsp_data,       64'd0);
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the model.
    task automatic step();
        logic [1:0]    exp_valid, exp_ready;
        bit            ep;
        int            n;
        exp_t          e;
        default_data_t w;
        default_strb_t s;
        default_data_t d;
        @(negedge clk);
        n = expq.size();
        exp_valid = 2'b00;
        if (n > 0) exp_valid[expq[0].port] = 1'b1;
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid));
        if (n > 0) chk("rsp_data", bus.rsp_data, expq[0].data);
        exp_ready = 2'b00;
        ep = 1'b0;
        if (n < RspDepth && bus.req_valid != 2'b00) begin
            ep = (bus.req_valid == 2'b11) ? ~last_gnt : bus.req_valid[1];
            exp_ready[ep] = 1'b1;
        end
        chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        chk("mem_cs", 64'(mem_cs), 64'(exp_ready != 2'b00));
        if (exp_ready != 2'b00) begin
            chk("mem_wen", 64'(mem_wen), 64'(bus.req_write[ep]));
            chk("mem_add", 64'(mem_add), 64'(bus.req_addr[ep]));
            if (bus.req_write[ep]) begin
                chk("mem_be", 64'(mem_be), 64'(bus.req_strb[ep]));
                chk("mem_wdata", mem_wdata, bus.req_data[ep]);
            end
        end else begin
            chk("mem_wen_idle", 64'(mem_wen), 64'd0);
        end
        for (int p = 0; p < 2; p++) begin
            if (bus.rsp_valid[p] && bus.rsp_ready[p]) begin
                comp[p]++;
                last_rsp = bus.rsp_data;
            end
            if (bus.req_ready[p]) grants[p]++;
        end
        if (n > 0 && bus.rsp_ready[expq[0].port]) void'(expq.pop_front());
        if (exp_ready != 2'b00) begin
            e.port = ep;
            e.data = bus.req_write[ep] ? 64'd0 : golden[bus.req_addr[ep]];
            if (bus.req_write[ep]) begin
                w = golden[bus.req_addr[ep]];
                s = bus.req_strb[ep];
                d = bus.req_data[ep];
                for (int b = 0; b < 8; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
                golden[bus.req_addr[ep]] = w;
            end
            expq.push_back(e);
            last_gnt = ep;
        end
        acc = bus.req_ready & bus.req_valid;
        @(posedge clk);
        #1;
    endtask

    // rdy_mode: 0 all ready, 1 port 1 stalled, 2 random per cycle.
    task automatic run(input int cycles, input logic [1:0] ports, input int wr_pct,
                       input int rdy_mode, input int max_new);
        int issued = 0;
        for (int c = 0; c < cycles; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!bus.req_valid[p] || acc[p]) begin
                    if (ports[p] && issued < max_new) begin
                        bus.req_valid[p] = 1'b1;
                        bus.req_write[p] = ($urandom_range(99) < wr_pct);
                        bus.req_addr[p]  = 10'($urandom_range(15));
                        bus.req_strb[p]  = 8'($urandom);
                        bus.req_data[p]  = {$urandom, $urandom};
                        issued++;
                    end else begin
                        bus.req_valid[p] = 1'b0;
                    end
                end
            end
            case (rdy_mode)
                0:       bus.rsp_ready = 2'b11;
                1:       bus.rsp_ready = 2'b01;
                default: bus.rsp_ready = 2'($urandom);
            endcase
            step();
            if (issued >= max_new && (bus.req_valid & ~acc) == 2'b00 && expq.size() == 0) break;
        end
        for (int p = 0; p < 2; p++) if (acc[p]) bus.req_valid[p] = 1'b0;
    endtask

    task automatic single(input bit p, input bit w, input int a,
                          input default_strb_t s, input default_data_t d);
        bus.rsp_ready    = 2'b11;
        bus.req_valid[p] = 1'b1;
        bus.req_write[p] = w;
        bus.req_addr[p]  = 10'(a);
        bus.req_strb[p]  = s;
        bus.req_data[p]  = d;
        step();
        for (int i = 0; i < 20 && !acc[p]; i++) step();
        chk("single_accept", 64'(acc[p]), 64'd1);
        bus.req_valid[p] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int            g0, c0, gsum, csum;
        default_data_t tmp, exp_rd;

        for (int a = 0; a < 1024; a++) golden[a] = init_word(a);
        rst_n         = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_write = 2'b00;
        bus.rsp_ready = 2'b00;
        for (int p = 0; p < 2; p++) begin
            bus.req_addr[p] = '0;
            bus.req_strb[p] = '0;
            bus.req_data[p] = '0;
            comp[p]   = 0;
            grants[p] = 0;
        end
        last_rsp = '0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Contention: alternating grants starting at port 0.
        run(8, 2'b11, 0, 0, 8);
        run(6, 2'b00, 0, 0, 0);
        chk("contention_grants0", 64'(grants[0]), 64'd4);
        chk("contention_grants1", 64'(grants[1]), 64'd4);
        chk("contention_rsp0", 64'(comp[0]), 64'd4);
        chk("contention_rsp1", 64'(comp[1]), 64'd4);

        // Single read with bypass in the following cycle.
        single(1'b0, 1'b0, 'h10, '0, '0);
        step();
        chk("single_read_data", last_rsp, 64'h0000_0000_DEAD_BEEF);
        step();

        // Backpressure on port 1: two grants, then stall until drained.
        g0 = grants[1];
        c0 = comp[1];
        run(6, 2'b10, 0, 1, 1000);
        chk("bp_grants", 64'(grants[1] - g0), 64'd2);
        chk("bp_no_rsp", 64'(comp[1] - c0), 64'd0);
        run(6, 2'b10, 0, 0, 1000);
        run(6, 2'b00, 0, 0, 0);
        chk("bp_all_answered", 64'(comp[1] - c0), 64'(grants[1] - g0));

        // Partial write then read-back.
        tmp    = golden[3];
        exp_rd = {tmp[63:32], 32'h5566_7788};
        single(1'b1, 1'b1, 3, 8'h0F, 64'h1122_3344_5566_7788);
        step();
        chk("write_ack_data", last_rsp, 64'd0);
        single(1'b1, 1'b0, 3, '0, '0);
        step();
        chk("write_readback", last_rsp, exp_rd);
        step();

        // Wrap-around: 20 reads under random response backpressure.
        gsum = grants[0] + grants[1];
        csum = comp[0] + comp[1];
        run(300, 2'b11, 0, 2, 20);
        run(10, 2'b00, 0, 0, 0);
        chk("wrap_grants", 64'(grants[0] + grants[1] - gsum), 64'd20);
        chk("wrap_rsps", 64'(comp[0] + comp[1] - csum), 64'd20);

        // Mixed reads and writes on both ports under random backpressure.
        gsum = grants[0] + grants[1];
        csum = comp[0] + comp[1];
        run(400, 2'b11, 40, 2, 40);
        run(10, 2'b00, 0, 0, 0);
        chk("mixed_grants", 64'(grants[0] + grants[1] - gsum), 64'd40);
        chk("mixed_rsps", 64'(comp[0] + comp[1] - csum), 64'd40);

        // Reset with one access in flight and one response buffered.
        run(2, 2'b10, 0, 1, 1000);
        bus.req_valid = 2'b00;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        c0 = comp[0] + comp[1];
        run(4, 2'b00, 0, 0, 0);
        chk("post_reset_no_rsp", 64'(comp[0] + comp[1] - c0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
